// File: rtl/raybox_pkg.sv
// rtl/raybox_pkg.sv - screen geometry and pixel classes shared by tracer, trace buffer and colour mapper
package raybox_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int HALF_H   = 240;

   typedef enum logic [1:0] {
      PIX_CEIL  = 2'd0,
      PIX_FLOOR = 2'd1,
      PIX_WALL0 = 2'd2,
      PIX_WALL1 = 2'd3
   } pix_class_t;

   function automatic logic [7:0] clamp_height(input logic [7:0] h, input logic [7:0] max_h);
      return (h > max_h) ? max_h : h;
   endfunction

endpackage

// File: rtl/trace_bank_ram.sv
// rtl/trace_bank_ram.sv - simple dual-port column RAM, one sync write port and one registered read port
module trace_bank_ram #(
   parameter int DEPTH = 640,
   parameter int AW    = 10,
   parameter int DW    = 9
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - double-buffered per-column trace store with per-pixel class lookup
// Define TRACE_BUFFER_SWAP_GATE_EN to refuse swaps until the back bank holds a complete frame.
module trace_buffer
   import raybox_pkg::*;
#(
   parameter int COLS  = SCREEN_W,
   parameter int ROWS  = SCREEN_H,
   parameter int MAX_H = HALF_H
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       store,
   input  logic [9:0] column,
   input  logic       side,
   input  logic [7:0] height,
   input  logic       swap_req,
   input  logic [9:0] rd_col,
   input  logic [9:0] rd_row,
   output logic [1:0] pix_class,
   output logic       valid,
   output logic       swapped,
   output logic       back_done
);

   localparam logic [9:0]  COLS_W   = 10'(COLS);
   localparam logic [9:0]  ROWS_W   = 10'(ROWS);
   localparam logic [9:0]  LAST_COL = 10'(COLS - 1);
   localparam logic [7:0]  MAX_H8   = 8'(MAX_H);
   localparam logic [10:0] MAX_H11  = 11'(MAX_H);

   logic       r_bank_sel;
   logic       r_sel_q;
   logic       r_q_ok;
   logic [9:0] r_row_q;

   logic       w_wr_ok, w_last, w_swap_ok, w_swap;
   logic       w_we0, w_we1;
   logic [8:0] w_wdata, w_q0, w_q1, w_front;
   logic [9:0] w_raddr;
   logic [10:0] w_h, w_lo, w_hi, w_row;

   assign w_wr_ok = store && (column < COLS_W);
   assign w_last  = w_wr_ok && (column == LAST_COL);

`ifdef TRACE_BUFFER_SWAP_GATE_EN
   assign w_swap_ok = back_done || w_last;
`else
   assign w_swap_ok = 1'b1;
`endif

   assign w_swap  = swap_req && w_swap_ok;
   assign w_wdata = {side, clamp_height(height, MAX_H8)};
   assign w_we0   = w_wr_ok && r_bank_sel;
   assign w_we1   = w_wr_ok && !r_bank_sel;
   assign w_raddr = (rd_col < COLS_W) ? rd_col : 10'd0;

   trace_bank_ram #(.DEPTH(COLS), .AW(10), .DW(9)) u_bank0 (
      .clk     (clk),
      .i_we    (w_we0),
      .i_waddr (column),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_q0)
   );

   trace_bank_ram #(.DEPTH(COLS), .AW(10), .DW(9)) u_bank1 (
      .clk     (clk),
      .i_we    (w_we1),
      .i_waddr (column),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_q1)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bank_sel <= 1'b0;
         r_sel_q    <= 1'b0;
         r_q_ok     <= 1'b0;
         r_row_q    <= 10'd0;
         valid      <= 1'b0;
         swapped    <= 1'b0;
         back_done  <= 1'b0;
      end else begin
         swapped <= w_swap;
         if (w_swap) begin
            r_bank_sel <= ~r_bank_sel;
            valid      <= 1'b1;
            back_done  <= 1'b0;
         end else if (w_last) begin
            back_done  <= 1'b1;
         end
         // Bank select is captured with the query so a same-cycle swap still reads the old front.
         r_sel_q <= r_bank_sel;
         r_q_ok  <= valid && (rd_col < COLS_W) && (rd_row < ROWS_W);
         r_row_q <= rd_row;
      end
   end

   assign w_front = r_sel_q ? w_q1 : w_q0;
   assign w_h     = {3'd0, w_front[7:0]};
   assign w_lo    = MAX_H11 - w_h;
   assign w_hi    = MAX_H11 + w_h;
   assign w_row   = {1'b0, r_row_q};

   // Decoded only from flops (RAM read register and captured query), so the class changes only on clock edges.
   always_comb begin
      pix_class = PIX_CEIL;
      if (r_q_ok) begin
         if (w_row >= w_lo && w_row < w_hi)
            pix_class = w_front[8] ? PIX_WALL1 : PIX_WALL0;
         else if (w_row < MAX_H11)
            pix_class = PIX_CEIL;
         else
            pix_class = PIX_FLOOR;
      end
   end

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - scoreboard bench for trace_buffer
module tb_trace_buffer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       store = 1'b0;
   logic [9:0] column = '0;
   logic       side = 1'b0;
   logic [7:0] height = '0;
   logic       swap_req = 1'b0;
   logic [9:0] rd_col = '0;
   logic [9:0] rd_row = '0;
   logic [1:0] pix_class;
   logic       valid, swapped, back_done;

   int checks = 0;
   int failures = 0;

   logic [1:0] exp_q [$];
   string      nm_q [$];
   logic       q_issue = 1'b0;
   logic       pend = 1'b0;
   logic [1:0] mon_exp;
   string      mon_nm;

   always #5 clk = ~clk;

   trace_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .store     (store),
      .column    (column),
      .side      (side),
      .height    (height),
      .swap_req  (swap_req),
      .rd_col    (rd_col),
      .rd_row    (rd_row),
      .pix_class (pix_class),
      .valid     (valid),
      .swapped   (swapped),
      .back_done (back_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge clk) pend <= q_issue;

   always @(negedge clk) begin
      if (pend) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_nm  = nm_q.pop_front();
            chk(mon_nm, {30'd0, pix_class}, {30'd0, mon_exp});
         end
      end
   end

   task automatic set_query(input logic [9:0] c, input logic [9:0] r, input logic [1:0] e, input string nm);
      rd_col  = c;
      rd_row  = r;
      q_issue = 1'b1;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   task automatic query(input logic [9:0] c, input logic [9:0] r, input logic [1:0] e, input string nm);
      set_query(c, r, e, nm);
      @(negedge clk);
      q_issue = 1'b0;
   endtask

   task automatic wr(input logic [9:0] c, input logic [7:0] h, input logic s);
      store  = 1'b1;
      column = c;
      height = h;
      side   = s;
      @(negedge clk);
      store  = 1'b0;
   endtask

   task automatic fill(input logic [7:0] h, input int sc, input logic [7:0] sh);
      for (int c = 0; c < 640; c++)
         wr(10'(c), (c == sc) ? sh : h, c[0]);
   endtask

   task automatic do_swap(input logic exp_sw, input string nm);
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
      chk(nm, {31'd0, swapped}, {31'd0, exp_sw});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_swapped", {31'd0, swapped}, 32'd0);
      chk("rst_back_done", {31'd0, back_done}, 32'd0);
      query(10'd100, 10'd240, 2'd0, "rst_query");

      // Frame 1: uniform half-height 120, side alternates with column parity.
      fill(8'd120, -1, 8'd0);
      chk("f1_back_done", {31'd0, back_done}, 32'd1);
      do_swap(1'b1, "f1_swapped");
      chk("f1_valid", {31'd0, valid}, 32'd1);
      chk("f1_back_done_clr", {31'd0, back_done}, 32'd0);
      query(10'd4, 10'd120, 2'd2, "f1_wall_top_s0");
      chk("f1_swapped_pulse", {31'd0, swapped}, 32'd0);
      query(10'd5, 10'd359, 2'd3, "f1_wall_bot_s1");
      query(10'd4, 10'd119, 2'd0, "f1_ceiling");
      query(10'd4, 10'd360, 2'd1, "f1_floor");
      query(10'd639, 10'd200, 2'd3, "f1_last_col");
      query(10'd640, 10'd100, 2'd0, "f1_col_oob");
      query(10'd4, 10'd480, 2'd0, "f1_row_oob");

      // Frame 2: column 10 overheight is clamped to full height.
      fill(8'd120, 10, 8'd255);
      do_swap(1'b1, "f2_swapped");
      query(10'd10, 10'd0, 2'd2, "f2_clamp_top");
      query(10'd10, 10'd479, 2'd2, "f2_clamp_bot");
      query(10'd11, 10'd0, 2'd0, "f2_neighbour");

      // Frame 3: zero height at column 20; query in the swap cycle sees the old front.
      fill(8'd120, 20, 8'd0);
      swap_req = 1'b1;
      set_query(10'd10, 10'd0, 2'd2, "f3_swapcycle_old");
      @(negedge clk);
      swap_req = 1'b0;
      q_issue  = 1'b0;
      chk("f3_swapped", {31'd0, swapped}, 32'd1);
      query(10'd10, 10'd0, 2'd0, "f3_new_front");
      query(10'd20, 10'd239, 2'd0, "f3_zero_ceil");
      query(10'd20, 10'd240, 2'd1, "f3_zero_floor");

      // Partial frame then swap request.
      for (int c = 0; c <= 300; c++)
         wr(10'(c), 8'd240, 1'b1);
      chk("part_back_done", {31'd0, back_done}, 32'd0);
`ifdef TRACE_BUFFER_SWAP_GATE_EN
      do_swap(1'b0, "part_no_swap");
      query(10'd0, 10'd0, 2'd0, "part_old_image");
      query(10'd20, 10'd240, 2'd1, "part_old_zero");
`else
      do_swap(1'b1, "part_swap");
      query(10'd0, 10'd0, 2'd3, "part_new_image");
      query(10'd400, 10'd0, 2'd0, "part_stale_ceil");
      query(10'd400, 10'd200, 2'd2, "part_stale_wall");
`endif
      store    = 1'b1;
      column   = 10'd639;
      height   = 8'd240;
      side     = 1'b1;
      swap_req = 1'b1;
      @(negedge clk);
      store    = 1'b0;
      swap_req = 1'b0;
      chk("last_swap_swapped", {31'd0, swapped}, 32'd1);
      chk("last_swap_bd", {31'd0, back_done}, 32'd0);
      query(10'd639, 10'd0, 2'd3, "last_swap_col639");
`ifdef TRACE_BUFFER_SWAP_GATE_EN
      query(10'd0, 10'd0, 2'd3, "last_swap_col0");
`else
      query(10'd0, 10'd0, 2'd0, "last_swap_col0");
`endif

      // Out-of-range column write must not alias.
      wr(10'd60, 8'd240, 1'b1);
      wr(10'd700, 8'd0, 1'b0);
      chk("oob_back_done", {31'd0, back_done}, 32'd0);
      wr(10'd639, 8'd120, 1'b0);
      chk("oob_back_done_set", {31'd0, back_done}, 32'd1);
      do_swap(1'b1, "oob_swapped");
      query(10'd60, 10'd0, 2'd3, "oob_col60_top");
      query(10'd60, 10'd479, 2'd3, "oob_col60_bot");
      query(10'd639, 10'd0, 2'd0, "oob_col639");

      // Reset in the middle of a fill.
      for (int c = 0; c < 100; c++)
         wr(10'(c), 8'd50, 1'b0);
      wr(10'd639, 8'd100, 1'b0);
      chk("mid_back_done", {31'd0, back_done}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst_valid", {31'd0, valid}, 32'd0);
      chk("mid_rst_bd", {31'd0, back_done}, 32'd0);
      chk("mid_rst_swapped", {31'd0, swapped}, 32'd0);
      query(10'd60, 10'd0, 2'd0, "mid_rst_query");

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
